hyperbus_clk_div: RTL and testbench
===================================

// Module: hyperbus_clk_div
// PURPOSE
//  Programmable, glitch-free integer clock divider that produces the fast clock
//  feeding the four-phase PHY clock generator. Runtime divider changes go through a
//  valid/ready handshake and take effect only at a falling-edge boundary of clk_o,
//  so no runt pulses ever reach the phase generator.
//  Start/stop via clk_en_i; the clock always parks low.
// PARAMETERS
//  DivWidth    8  width of divider config; half-period = div cycles of clk_i
//  DefaultDiv  1  half-period loaded at reset (must be >= 1)
// PORTS
//  clk_i        in   1         source clock; all logic on posedge
//  rst_i        in   1         synchronous, active-high reset
//  clk_en_i     in   1         1: run divided clock, 0: park clk_o low
//  cfg_div_i    in   DivWidth  requested half-period in clk_i cycles (0 treated as 1)
//  cfg_valid_i  in   1         cfg_div_i valid
//  cfg_ready_o  out  1         divider can accept a new config
//  div_o        out  DivWidth  currently active half-period
//  running_o    out  1         1 while FSM in RUN
//  clk_o        out  1         divided clock, registered output, period 2*div_o
// BEHAVIOUR
//  Reset: clk_o=0, running_o=0, cfg_ready_o=1, div_o=DefaultDiv, cnt=0, pend_vld=0, state IDLE.
//  Reset mid-operation: same values at the next edge; may truncate a high phase (accepted).
//  Config sanitise: stored value = (cfg_div_i==0) ? 1 : cfg_div_i.
//  Handshake: accept when cfg_valid_i & cfg_ready_o at posedge.
//   - IDLE: div_o <= value next cycle; cfg_ready_o stays 1.
//   - RUN: pend_div <= value, pend_vld <= 1, cfg_ready_o = 0 until applied.
//   - cfg_ready_o = ~pend_vld (registered term only, no comb path from cfg_valid_i).
//  FSM states:
//   IDLE: clk_o=0, cnt=0. If clk_en_i=1 at edge k -> RUN; clk_o=1, cnt=0 after edge k.
//   RUN: if cnt == div_o-1:
//    - cnt <= 0, clk_o <= ~clk_o.
//    - falling toggle (clk_o was 1):
//      - if pend_vld: div_o <= pend_div, pend_vld <= 0.
//      - if clk_en_i=0: -> IDLE.
//    Else cnt <= cnt+1.
//   clk_en_i is only sampled at falling toggles in RUN; high phase is never cut short.
//   Each phase lasts exactly div_o clk_i cycles. cnt is DivWidth bits and never exceeds div_o-1.
//  Simultaneous events:
//   - Handshake in the same cycle as a falling toggle: stored as pending and applied
//     at the NEXT falling toggle (apply uses the registered pend_div only).
//   - Falling toggle with clk_en_i=0 and pend_vld=1: pending applied, then IDLE.
//  Max divide: cfg 2^DivWidth-1 legal; no wrap of cnt.
//  running_o = (state==RUN).
//  Latency: clk_en_i rise -> clk_o rise 1 cycle; cfg in IDLE -> div_o 1 cycle.
// TESTING
//  1) Reset, DefaultDiv=1, clk_en_i=1 -> clk_o toggles every cycle, period 2, running_o=1.
//  2) IDLE, cfg 3, then clk_en_i=1 -> div_o=3; clk_o high 3 / low 3; first rise 1 cycle after enable.
//  3) RUN div=3, cfg 2 mid high phase -> cfg_ready_o=0 until falling toggle;
//     old high phase keeps 3 cycles, then low/high phases 2 cycles; cfg_ready_o returns to 1.
//  4) RUN div=4, clk_en_i=0 one cycle into high phase -> high completes 4 cycles;
//     then clk_o=0, running_o=0, cnt=0, stays low.
//  5) cfg_div_i=0 accepted -> div_o=1.
//     Handshake exactly at a falling toggle -> not applied until the following falling toggle.
//  6) rst_i asserted mid high phase (div=5) -> next edge clk_o=0, div_o=DefaultDiv,
//     pend_vld=0, cfg_ready_o=1.

Source files
------------

// File: rtl/hyperbus_clk_div.sv
// Glitch-free integer clock divider for the HyperBus PHY phase generator.
// The divider is reloaded only on a falling toggle of clk_o, and the output always parks low.
module hyperbus_clk_div #(
  parameter int unsigned DivWidth   = 8,
  parameter int unsigned DefaultDiv = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clk_en_i,
  input  logic [DivWidth-1:0] cfg_div_i,
  input  logic                cfg_valid_i,
  output logic                cfg_ready_o,
  output logic [DivWidth-1:0] div_o,
  output logic                running_o,
  output logic                clk_o
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  localparam logic [DivWidth-1:0] DivOne = DivWidth'(1);
  localparam logic [DivWidth-1:0] DivRst = DivWidth'(DefaultDiv);

  // A half-period of zero cycles is meaningless, so treat it as one.
  function automatic logic [DivWidth-1:0] sanitize_div(input logic [DivWidth-1:0] d);
    return (d == '0) ? DivOne : d;
  endfunction

  logic [0:0]          state_q, state_d;
  logic                clk_q, clk_d;
  logic [DivWidth-1:0] cnt_q, cnt_d;
  logic [DivWidth-1:0] div_q, div_d;
  logic [DivWidth-1:0] pend_div_q, pend_div_d;
  logic                pend_vld_q, pend_vld_d;

  logic                accept;
  logic                phase_end;

  assign accept    = cfg_valid_i & ~pend_vld_q;
  assign phase_end = (cnt_q == (div_q - DivOne));

  always_comb begin
    state_d    = state_q;
    clk_d      = clk_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_div_d = pend_div_q;
    pend_vld_d = pend_vld_q;

    case (state_q)
      StIdle: begin
        cnt_d = '0;
        clk_d = 1'b0;
        // A config that arrived on the last falling toggle before stopping is applied here.
        if (pend_vld_q) begin
          div_d      = pend_div_q;
          pend_vld_d = 1'b0;
        end
        if (accept) begin
          div_d = sanitize_div(cfg_div_i);
        end
        if (clk_en_i) begin
          state_d = StRun;
          clk_d   = 1'b1;
        end
      end

      StRun: begin
        if (phase_end) begin
          cnt_d = '0;
          clk_d = ~clk_q;
          if (clk_q) begin
            if (pend_vld_q) begin
              div_d      = pend_div_q;
              pend_vld_d = 1'b0;
            end
            if (!clk_en_i) begin
              state_d = StIdle;
            end
          end
        end else begin
          cnt_d = cnt_q + DivOne;
        end
        // Accept needs pend_vld_q low, so it never collides with an apply in the same cycle.
        if (accept) begin
          pend_div_d = sanitize_div(cfg_div_i);
          pend_vld_d = 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
        clk_d   = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      clk_q      <= 1'b0;
      cnt_q      <= '0;
      div_q      <= DivRst;
      pend_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_q      <= clk_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_vld_q <= pend_vld_d;
    end
  end

  // The pending value is only consumed when pend_vld_q is set, so it needs no reset.
  always_ff @(posedge clk_i) begin
    pend_div_q <= pend_div_d;
  end

  assign cfg_ready_o = ~pend_vld_q;
  assign div_o       = div_q;
  assign running_o   = (state_q == StRun);
  assign clk_o       = clk_q;

endmodule

// File: tb/tb_hyperbus_clk_div.sv
// Bench for hyperbus_clk_div: directed scenarios followed by random traffic,
// every cycle compared against a phase-level model of the divided clock.
module tb_hyperbus_clk_div;

  localparam int DW  = 8;
  localparam int DEF = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          clk_en;
  logic [DW-1:0] cfg_div;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [DW-1:0] div_o;
  logic          running;
  logic          clk_o;

  hyperbus_clk_div #(.DivWidth(DW), .DefaultDiv(DEF)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .clk_en_i   (clk_en),
    .cfg_div_i  (cfg_div),
    .cfg_valid_i(cfg_valid),
    .cfg_ready_o(cfg_ready),
    .div_o      (div_o),
    .running_o  (running),
    .clk_o      (clk_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int fails = 0;

  // Model: is the clock running, its level, cycles left in this phase,
  // the active half-period, and at most one config waiting for a falling edge.
  bit m_run;
  bit m_clk;
  int m_left;
  int m_div;
  int m_pend[$];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit acc;
    int val;
    acc = cfg_valid && (m_pend.size() == 0);
    val = (cfg_div == 0) ? 1 : int'(cfg_div);
    if (rst) begin
      m_run = 0; m_clk = 0; m_left = 0; m_div = DEF; m_pend.delete();
    end else if (!m_run) begin
      if (m_pend.size() != 0) m_div = m_pend.pop_front();
      if (acc) m_div = val;
      if (clk_en) begin
        m_run = 1; m_clk = 1; m_left = m_div;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        if (m_clk) begin
          if (m_pend.size() != 0) m_div = m_pend.pop_front();
          if (!clk_en) m_run = 0;
        end
        m_clk  = ~m_clk;
        m_left = m_div;
      end
      if (acc) m_pend.push_back(val);
    end
  endtask

  task automatic step(input logic en, input logic v, input logic [DW-1:0] d, input logic r);
    rst = r; clk_en = en; cfg_valid = v; cfg_div = d;
    @(posedge clk);
    model_edge();
    #1;
    chk("clk_o",       {7'b0, clk_o},     {7'b0, m_clk});
    chk("running_o",   {7'b0, running},   {7'b0, m_run});
    chk("cfg_ready_o", {7'b0, cfg_ready}, {7'b0, (m_pend.size() == 0)});
    chk("div_o",       div_o,             DW'(m_div));
  endtask

  initial begin
    bit found;
    int hi;
    rst = 1; clk_en = 0; cfg_valid = 0; cfg_div = '0;
    m_run = 0; m_clk = 0; m_left = 0; m_div = DEF;

    // 1) reset values, then free-running at the default half-period
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("rst_clk",   {7'b0, clk_o},     8'd0);
    chk("rst_run",   {7'b0, running},   8'd0);
    chk("rst_ready", {7'b0, cfg_ready}, 8'd1);
    chk("rst_div",   div_o,             8'(DEF));
    step(1, 0, 0, 0);
    chk("t1_first_rise", {7'b0, clk_o}, 8'd1);
    step(1, 0, 0, 0);
    chk("t1_fall", {7'b0, clk_o}, 8'd0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0);

    // 2) stop, configure 3 while idle, then enable
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    step(0, 1, 8'd3, 0);
    chk("t2_div_idle", div_o, 8'd3);
    step(1, 0, 0, 0);
    chk("t2_first_rise", {7'b0, clk_o}, 8'd1);
    hi = 1;
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0);
      if (clk_o) hi++;
    end
    chk("t2_high_len", 8'(hi), 8'd3);

    // 3) reconfigure to 2 in the middle of a high phase
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_clk && m_left == 2) found = 1;
      else step(1, 0, 0, 0);
    end
    chk("t3_found_high", {7'b0, found}, 8'd1);
    step(1, 1, 8'd2, 0);
    chk("t3_ready_low", {7'b0, cfg_ready}, 8'd0);
    for (int i = 0; i < 12; i++) step(1, 0, 0, 0);
    chk("t3_div_new", div_o, 8'd2);
    chk("t3_ready_back", {7'b0, cfg_ready}, 8'd1);

    // 4) div 4, drop enable one cycle into a high phase
    step(1, 1, 8'd4, 0);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      step(1, 0, 0, 0);
      if (m_div == 4 && m_clk && m_left == 4) found = 1;
    end
    chk("t4_found_rise", {7'b0, found}, 8'd1);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
    chk("t4_parked_clk", {7'b0, clk_o},   8'd0);
    chk("t4_parked_run", {7'b0, running}, 8'd0);

    // 5) zero config, and a handshake exactly on a falling toggle
    step(0, 1, 8'd0, 0);
    chk("t5_zero_div", div_o, 8'd1);
    step(0, 1, 8'd2, 0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_run && m_clk && m_left == 1) found = 1;
      else step(1, 0, 0, 0);
    end
    chk("t5_found_fall", {7'b0, found}, 8'd1);
    step(1, 1, 8'd5, 0);
    chk("t5_not_applied", div_o, 8'd2);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0);
    chk("t5_applied", div_o, 8'd5);

    // 6) reset in the middle of a div=5 high phase with a config pending
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_clk && m_left == 3) found = 1;
      else step(1, 0, 0, 0);
    end
    chk("t6_found_high", {7'b0, found}, 8'd1);
    step(1, 1, 8'd7, 0);
    step(1, 0, 0, 1);
    chk("t6_clk",   {7'b0, clk_o},     8'd0);
    chk("t6_div",   div_o,             8'(DEF));
    chk("t6_ready", {7'b0, cfg_ready}, 8'd1);
    chk("t6_run",   {7'b0, running},   8'd0);

    // 7) random traffic, including the maximum half-period once
    step(0, 1, 8'd255, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 520; i++) step(1, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 7) != 0), ($urandom_range(0, 5) == 0),
           DW'($urandom_range(0, 6)), ($urandom_range(0, 299) == 0));
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
